// File: rtl/jtag_tap_ctrl_if.sv
// Pin-level JTAG signals plus the CPU debug-unit word exchange for the TAP controller.
// The master side drives the pins and the read data. The slave side is the TAP controller.
interface jtag_tap_ctrl_if;
    logic        tck;
    logic        tms;
    logic        tdi;
    logic        trst;
    logic        tdo;
    logic [31:0] dbg_rd_data;
    logic        dbg_rd_ack;
    logic [31:0] dbg_wr_data;
    logic        dbg_wr_valid;
    logic [3:0]  tap_state;

    modport master (
        output tck, tms, tdi, trst, dbg_rd_data,
        input  tdo, dbg_rd_ack, dbg_wr_data, dbg_wr_valid, tap_state
    );

    modport slave (
        input  tck, tms, tdi, trst, dbg_rd_data,
        output tdo, dbg_rd_ack, dbg_wr_data, dbg_wr_valid, tap_state
    );
endinterface

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller running entirely on clk; tck is oversampled and treated as data.
// Provides IR, IDCODE, BYPASS and a 32-bit USER register that trades words with the CPU debug unit.
//
// state | meaning
// TLR   | test-logic-reset, IR forced to IDCODE
// RTI   | run-test/idle
// *DR   | select/capture/shift/exit1/pause/exit2/update of the data-register column
// *IR   | same sequence for the instruction-register column
module jtag_tap_ctrl #(
    parameter int unsigned         IR_WIDTH    = 4,
    parameter logic [31:0]         IDCODE_VAL  = 32'h1000_0001,
    parameter logic [IR_WIDTH-1:0] USER_IR     = IR_WIDTH'(2),
    parameter int unsigned         SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    jtag_tap_ctrl_if.slave tap_if
);
    typedef enum logic [3:0] {
        TLR   = 4'd0,  RTI   = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
        SH_DR = 4'd4,  EX1_DR = 4'd5, PAU_DR = 4'd6,  EX2_DR = 4'd7,
        UPD_DR = 4'd8, SEL_IR = 4'd9, CAP_IR = 4'd10, SH_IR  = 4'd11,
        EX1_IR = 4'd12, PAU_IR = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
    } tap_state_e;

    logic [SYNC_STAGES-1:0] tck_sync_q, tms_sync_q, tdi_sync_q, trst_sync_q;
    logic                   tck_q;
    logic                   tck_s, tms_s, tdi_s, trst_s, rise, fall;

    tap_state_e          state_q, state_d;
    logic [IR_WIDTH-1:0] ir_q, ir_sh_q;
    logic [31:0]         dr_sh_q, wr_data_q;
    logic                byp_q, tdo_q, rd_ack_q, wr_valid_q;
    logic                act_tlr, cap_ir, sh_ir, upd_ir, cap_dr, sh_dr, upd_dr;
    logic                sel_idcode, sel_user, sel_bypass;

    always_ff @(posedge clk) begin
        if (rst) begin
            tck_sync_q  <= '0;
            tms_sync_q  <= '0;
            tdi_sync_q  <= '0;
            trst_sync_q <= '0;
        end else begin
            tck_sync_q  <= {tck_sync_q[SYNC_STAGES-2:0],  tap_if.tck};
            tms_sync_q  <= {tms_sync_q[SYNC_STAGES-2:0],  tap_if.tms};
            tdi_sync_q  <= {tdi_sync_q[SYNC_STAGES-2:0],  tap_if.tdi};
            trst_sync_q <= {trst_sync_q[SYNC_STAGES-2:0], tap_if.trst};
        end
    end

    assign tck_s  = tck_sync_q[SYNC_STAGES-1];
    assign tms_s  = tms_sync_q[SYNC_STAGES-1];
    assign tdi_s  = tdi_sync_q[SYNC_STAGES-1];
    assign trst_s = trst_sync_q[SYNC_STAGES-1];
    assign rise   = tck_s & ~tck_q;
    assign fall   = ~tck_s & tck_q;

    // Holding tck_q at 0 through a reset means a high tck afterwards still yields one rise.
    always_ff @(posedge clk) begin
        if (rst || trst_s) tck_q <= 1'b0;
        else               tck_q <= tck_s;
    end

    assign sel_idcode = (ir_q == IR_WIDTH'(1));
    assign sel_user   = !sel_idcode && (ir_q == USER_IR);
    assign sel_bypass = !sel_idcode && !sel_user;

    always_ff @(posedge clk) begin
        if (rst || trst_s) state_q <= TLR;
        else               state_q <= state_d;
    end

    // The action strobes belong to the state being left on this rise.
    always_comb begin
        state_d = state_q;
        act_tlr = 1'b0;
        cap_ir  = 1'b0;
        sh_ir   = 1'b0;
        upd_ir  = 1'b0;
        cap_dr  = 1'b0;
        sh_dr   = 1'b0;
        upd_dr  = 1'b0;
        if (rise && !trst_s) begin
            case (state_q)
                TLR:    begin act_tlr = 1'b1; state_d = tms_s ? TLR : RTI; end
                RTI:    state_d = tms_s ? SEL_DR : RTI;
                SEL_DR: state_d = tms_s ? SEL_IR : CAP_DR;
                CAP_DR: begin cap_dr = 1'b1; state_d = tms_s ? EX1_DR : SH_DR; end
                SH_DR:  begin sh_dr = 1'b1; state_d = tms_s ? EX1_DR : SH_DR; end
                EX1_DR: state_d = tms_s ? UPD_DR : PAU_DR;
                PAU_DR: state_d = tms_s ? EX2_DR : PAU_DR;
                EX2_DR: state_d = tms_s ? UPD_DR : SH_DR;
                UPD_DR: begin upd_dr = 1'b1; state_d = tms_s ? SEL_DR : RTI; end
                SEL_IR: state_d = tms_s ? TLR : CAP_IR;
                CAP_IR: begin cap_ir = 1'b1; state_d = tms_s ? EX1_IR : SH_IR; end
                SH_IR:  begin sh_ir = 1'b1; state_d = tms_s ? EX1_IR : SH_IR; end
                EX1_IR: state_d = tms_s ? UPD_IR : PAU_IR;
                PAU_IR: state_d = tms_s ? EX2_IR : PAU_IR;
                EX2_IR: state_d = tms_s ? UPD_IR : SH_IR;
                UPD_IR: begin upd_ir = 1'b1; state_d = tms_s ? SEL_DR : RTI; end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || trst_s) begin
            ir_q       <= IR_WIDTH'(1);
            ir_sh_q    <= '0;
            dr_sh_q    <= '0;
            byp_q      <= 1'b0;
            tdo_q      <= 1'b0;
            rd_ack_q   <= 1'b0;
            wr_valid_q <= 1'b0;
        end else begin
            rd_ack_q   <= 1'b0;
            wr_valid_q <= 1'b0;
            if (act_tlr) ir_q <= IR_WIDTH'(1);
            if (upd_ir)  ir_q <= ir_sh_q;
            if (cap_ir)  ir_sh_q <= IR_WIDTH'(1);
            if (sh_ir)   ir_sh_q <= {tdi_s, ir_sh_q[IR_WIDTH-1:1]};
            if (cap_dr) begin
                if (sel_idcode) begin
                    dr_sh_q <= IDCODE_VAL;
                end else if (sel_user) begin
                    dr_sh_q  <= tap_if.dbg_rd_data;
                    rd_ack_q <= 1'b1;
                end else begin
                    byp_q <= 1'b0;
                end
            end
            if (sh_dr) begin
                if (sel_bypass) byp_q   <= tdi_s;
                else            dr_sh_q <= {tdi_s, dr_sh_q[31:1]};
            end
            if (upd_dr && sel_user) wr_valid_q <= 1'b1;
            if (fall) begin
                if (state_q == SH_IR)      tdo_q <= ir_sh_q[0];
                else if (state_q == SH_DR) tdo_q <= sel_bypass ? byp_q : dr_sh_q[0];
                else                       tdo_q <= 1'b0;
            end
        end
    end

    // A test reset alone leaves the last delivered word in place.
    always_ff @(posedge clk) begin
        if (rst)                    wr_data_q <= '0;
        else if (upd_dr && sel_user) wr_data_q <= dr_sh_q;
    end

    assign tap_if.tdo          = tdo_q;
    assign tap_if.dbg_rd_ack   = rd_ack_q;
    assign tap_if.dbg_wr_data  = wr_data_q;
    assign tap_if.dbg_wr_valid = wr_valid_q;
    assign tap_if.tap_state    = state_q;
endmodule
